// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 16-channel TDM path.
// Also reused by the transmit-side scanner.
package tdm_pkg;

  localparam int N_CH = 16;
  localparam int IDX_W = 4;

  localparam logic [IDX_W-1:0] FRAME_LAST = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/demux1_4.sv
// Registered 1:4 write-enable decoder.
// q holds the one-hot decode of sel, gated by en.
module demux1_4 #(
  parameter logic [3:0] RST_Q = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] q
);

  logic [3:0] dec;

  always_comb begin
    dec = 4'b0000;
    if (en) begin
      unique case (1'b1)
        (sel == 2'd0): dec = 4'b0001;
        (sel == 2'd1): dec = 4'b0010;
        (sel == 2'd2): dec = 4'b0100;
        (sel == 2'd3): dec = 4'b1000;
        default:       dec = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_Q;
    else        q <= dec;
  end

endmodule

// File: rtl/tdm_demux16.sv
// 16-channel TDM demultiplexer: serial beats to a registered 16-bit word.
// Slot enables are a registered decode of the next index, ready at each beat.
module tdm_demux16
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [N_CH-1:0]  dout,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked,
  output logic [IDX_W-1:0] ch_idx
);

  state_t            state;
  state_t            state_n;
  logic [IDX_W-1:0]  idx_n;
  logic [N_CH-1:0]   shadow;
  logic [N_CH-1:0]   shadow_n;
  logic [N_CH-1:0]   wr;
  logic [N_CH-1:0]   slot;
  logic              load;
  logic              fd_n;
  logic              se_n;
  logic [3:0]        hi_q;
  logic [3:0]        lo_q [4];

  // Nibble select: top level of the inverted mux tree
  demux1_4 #(.RST_Q(4'b0001)) u_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (idx_n[3:2]),
    .en    (1'b1),
    .q     (hi_q)
  );

  for (genvar n = 0; n < 4; n++) begin : g_lo
    localparam logic [3:0] RQ = (n == 0) ? 4'b0001 : 4'b0000;

    demux1_4 #(.RST_Q(RQ)) u_lo (
      .clk   (clk),
      .rst_n (rst_n),
      .sel   (idx_n[1:0]),
      .en    (idx_n[3:2] == 2'(n)),
      .q     (lo_q[n])
    );

    assign slot[4*n +: 4] = lo_q[n] & {4{hi_q[n]}};
  end

  always_comb begin
    state_n = state;
    idx_n   = ch_idx;
    wr      = '0;
    load    = 1'b0;
    fd_n    = 1'b0;
    se_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (din_valid && frame_start) begin
          wr      = 16'h0001;
          idx_n   = 4'd1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (din_valid) begin
          if (frame_start || ch_idx == '0) begin
            se_n  = frame_start && (ch_idx != '0);
            wr    = 16'h0001;
            idx_n = 4'd1;
          end else begin
            wr = slot;
            if (ch_idx == FRAME_LAST) begin
              load  = 1'b1;
              fd_n  = 1'b1;
              idx_n = '0;
            end else begin
              idx_n = ch_idx + 4'd1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
    shadow_n = (shadow & ~wr) | (wr & {N_CH{din}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch_idx     <= '0;
      shadow     <= '0;
      dout       <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_n;
      ch_idx     <= idx_n;
      shadow     <= shadow_n;
      frame_done <= fd_n;
      sync_err   <= se_n;
      // shadow_n already carries din in bit 15 on the completing beat
      if (load) dout <= shadow_n;
    end
  end

  assign locked = (state == RUN);

endmodule

// File: tb/tb_tdm_demux16.sv
// Randomized and directed bench for tdm_demux16.
// Reference model tracks frame position and collected bits per channel.
module tb_tdm_demux16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] dout;
  logic        frame_done;
  logic        sync_err;
  logic        locked;
  logic [3:0]  ch_idx;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int fd_last = 0;
  int fd_prev = 0;

  bit          m_lock;
  int          m_pos;
  bit          m_bits [16];
  logic [15:0] m_dout;
  bit          m_fd;
  bit          m_se;

  tdm_demux16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .dout        (dout),
    .frame_done  (frame_done),
    .sync_err    (sync_err),
    .locked      (locked),
    .ch_idx      (ch_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 0;
    m_pos  = 0;
    m_dout = '0;
    m_fd   = 0;
    m_se   = 0;
    foreach (m_bits[k]) m_bits[k] = 0;
  endtask

  task automatic model_step(input bit v, input bit fs, input bit d);
    m_fd = 0;
    m_se = 0;
    if (!v) return;
    if (!m_lock) begin
      if (fs) begin
        m_bits[0] = d;
        m_pos = 1;
        m_lock = 1;
      end
    end else if (fs || m_pos == 0) begin
      m_se = fs && m_pos != 0;
      m_bits[0] = d;
      m_pos = 1;
    end else begin
      m_bits[m_pos] = d;
      if (m_pos == 15) begin
        for (int k = 0; k < 16; k++) m_dout[k] = m_bits[k];
        m_fd = 1;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic check_all();
    chk("dout", dout, m_dout);
    chk("frame_done", frame_done, m_fd);
    chk("sync_err", sync_err, m_se);
    chk("locked", locked, m_lock);
    chk("ch_idx", ch_idx, m_pos);
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_prev = fd_last;
      fd_last = cyc;
    end
  endtask

  task automatic tick(input bit v, input bit fs, input bit d);
    din_valid   = v;
    frame_start = fs;
    din         = d;
    @(posedge clk);
    cyc++;
    model_step(v, fs, d);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_dout", dout, 16'h0000);
    chk("rst_locked", locked, 1'b0);
    chk("rst_ch_idx", ch_idx, 4'd0);
    chk("rst_pulses", {frame_done, sync_err}, 2'b00);
    din_valid   = 1'b0;
    frame_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] w, input bit mark,
                            input bit gap);
    for (int k = 0; k < 16; k++) begin
      if (gap && k > 0) tick(0, 0, 1'($urandom));
      tick(1, mark && k == 0, w[k]);
    end
  endtask

  initial begin
    logic [15:0] w;
    model_reset();
    #12;
    do_reset();

    // full marked frame
    fd_cnt = 0;
    send_frame(16'hA5C3, 1, 0);
    chk("t1_done", frame_done, 1'b1);
    chk("t1_dout", dout, 16'hA5C3);
    tick(0, 0, 0);
    chk("t1_fd_cnt", fd_cnt, 1);

    // unmarked beats after reset are dropped
    do_reset();
    w = 16'h00FF;
    for (int k = 0; k < 8; k++) tick(1, 0, w[k]);
    chk("t2_locked", locked, 1'b0);
    chk("t2_idx", ch_idx, 4'd0);
    send_frame(16'h1234, 1, 0);
    chk("t2_dout", dout, 16'h1234);

    // back-to-back frames, marker only on the first
    fd_cnt = 0;
    send_frame(16'hFFFF, 1, 0);
    chk("t3_dout_a", dout, 16'hFFFF);
    send_frame(16'h0001, 0, 0);
    chk("t3_dout_b", dout, 16'h0001);
    chk("t3_fd_cnt", fd_cnt, 2);
    chk("t3_spacing", fd_last - fd_prev, 16);

    // gapped beats
    send_frame(16'h8001, 1, 1);
    chk("t4_done", frame_done, 1'b1);
    chk("t4_dout", dout, 16'h8001);

    // mid-frame resync
    fd_cnt = 0;
    w = 16'h5555;
    tick(1, 1, w[0]);
    for (int k = 1; k < 6; k++) tick(1, 0, w[k]);
    tick(1, 1, 1'b0);
    chk("t5_sync_err", sync_err, 1'b1);
    for (int k = 1; k < 16; k++) tick(1, 0, k >= 4 && k < 8);
    chk("t5_dout", dout, 16'h00F0);
    chk("t5_fd_cnt", fd_cnt, 1);

    // reset mid-frame
    w = 16'hBEEF;
    tick(1, 1, w[0]);
    for (int k = 1; k < 9; k++) tick(1, 0, w[k]);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_dout", dout, 16'h0000);
    chk("t6_locked", locked, 1'b0);
    chk("t6_idx", ch_idx, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 9; k < 16; k++) tick(1, 0, w[k]);
    chk("t6_post_locked", locked, 1'b0);
    chk("t6_post_dout", dout, 16'h0000);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
           1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
